// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper: FSM state encoding,
// default sizing constants and the truth-table width helper.
package truth_table_sweeper_pkg;

    // Default number of inputs of the function under test.
    localparam int DEF_N_IN   = 5;
    // Default number of extra hold cycles per vector before sampling.
    localparam int DEF_SETTLE = 1;
    // Width of the settle counter; SETTLE is limited to 0..15.
    localparam int SETTLE_CW  = 4;

    // Sweep controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Number of rows in the truth table of an n-input function.
    function automatic int tt_w(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_index_counter.sv
// sweep_index_counter: settle counter plus vector index counter.
// Each vector is held for SETTLE+1 enabled cycles; o_sample marks the last
// cycle of that window. The index stops at the last vector, so no wrap to
// vector 0 is ever presented to the function under test.
module sweep_index_counter
    import truth_table_sweeper_pkg::*;
#(
    parameter int N_IN   = DEF_N_IN,
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_clear,
    input  logic            i_en,
    output logic [N_IN-1:0] o_index,
    output logic            o_sample,
    output logic            o_last
);

    localparam logic [SETTLE_CW-1:0] SETTLE_C = SETTLE_CW'(SETTLE);
    localparam logic [N_IN-1:0]      LAST_IDX = '1;

    logic [SETTLE_CW-1:0] r_cnt;
    logic [N_IN-1:0]      r_index;
    logic                 w_window_end;

    assign w_window_end = (r_cnt == SETTLE_C);
    assign o_index      = r_index;
    assign o_sample     = i_en && w_window_end;
    assign o_last       = (r_index == LAST_IDX);

    // Advance the settle count each enabled cycle; step the index at window end.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_index <= '0;
        end else if (i_clear) begin
            r_cnt   <= '0;
            r_index <= '0;
        end else if (i_en) begin
            if (w_window_end) begin
                r_cnt <= '0;
                if (!o_last) begin
                    r_index <= r_index + {{(N_IN-1){1'b0}}, 1'b1};
                end
            end else begin
                r_cnt <= r_cnt + {{(SETTLE_CW-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: walks an external N_IN-input combinational function
// through every input vector, captures its output into a truth table and
// compares it with an expected minterm mask.
// Optional feature macro: TRUTH_TABLE_SWEEPER_MISMATCH_COUNT_EN adds the
// fail_count output counting every mismatching index.
//
// Control semantics: start is a level sampled only in IDLE; when seen there
// it is consumed on that edge and expected is latched. abort is sampled in
// every state, wins over start, and returns the block to IDLE on the next
// edge without a done pulse. done is a single-cycle pulse.
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter  int N_IN   = DEF_N_IN,
    parameter  int SETTLE = DEF_SETTLE,
    localparam int TT_W   = tt_w(N_IN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [TT_W-1:0] expected,
    output logic [N_IN-1:0] f_in,
    input  logic            f_out,
    output logic            busy,
    output logic            done,
    output logic [TT_W-1:0] truth_table,
    output logic            pass,
    output logic [N_IN-1:0] first_fail,
    output logic            aborted,
`ifdef TRUTH_TABLE_SWEEPER_MISMATCH_COUNT_EN
    output logic [N_IN:0]   fail_count,
`endif
    output logic [1:0]      o_dbg_state
);

    state_t          r_state;
    state_t          w_next;
    logic            r_busy;
    logic            r_done;
    logic [TT_W-1:0] r_exp;
    logic [TT_W-1:0] r_tt;
    logic            r_pass;
    logic            r_fail;
    logic [N_IN-1:0] r_first_fail;
    logic            r_aborted;
`ifdef TRUTH_TABLE_SWEEPER_MISMATCH_COUNT_EN
    logic [N_IN:0]   r_fail_cnt;
`endif

    logic            w_accept;
    logic            w_clear;
    logic            w_en;
    logic [N_IN-1:0] w_index;
    logic            w_sample;
    logic            w_last;
    logic            w_mismatch;

    // Start is only honoured from IDLE, and abort always takes priority.
    assign w_accept   = (r_state == ST_IDLE) && start;
    assign w_clear    = w_accept && !abort;
    assign w_en       = (r_state == ST_SWEEP) && !abort;
    assign w_mismatch = (f_out != r_exp[w_index]);

    sweep_index_counter #(
        .N_IN   (N_IN),
        .SETTLE (SETTLE)
    ) u_index_counter (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_clear  (w_clear),
        .i_en     (w_en),
        .o_index  (w_index),
        .o_sample (w_sample),
        .o_last   (w_last)
    );

    // State register plus registered busy/done decoded from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == ST_SWEEP);
            r_done  <= (w_next == ST_DONE);
        end
    end

    // Next-state logic: IDLE -> SWEEP on start, SWEEP -> DONE after the last
    // vector is sampled, DONE -> IDLE unconditionally; abort forces IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                if (w_sample && w_last) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
        if (abort) begin
            w_next = ST_IDLE;
        end
    end

    // Capture register and mismatch tracking; the verdict is registered on
    // the final sample so it appears together with done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_exp        <= '0;
            r_tt         <= '0;
            r_pass       <= 1'b0;
            r_fail       <= 1'b0;
            r_first_fail <= '0;
            r_aborted    <= 1'b0;
`ifdef TRUTH_TABLE_SWEEPER_MISMATCH_COUNT_EN
            r_fail_cnt   <= '0;
`endif
        end else if (abort) begin
            r_aborted <= 1'b1;
            r_pass    <= 1'b0;
        end else if (w_accept) begin
            r_exp        <= expected;
            r_tt         <= '0;
            r_pass       <= 1'b0;
            r_fail       <= 1'b0;
            r_first_fail <= '0;
            r_aborted    <= 1'b0;
`ifdef TRUTH_TABLE_SWEEPER_MISMATCH_COUNT_EN
            r_fail_cnt   <= '0;
`endif
        end else if (w_sample) begin
            r_tt[w_index] <= f_out;
            if (w_mismatch) begin
                if (!r_fail) begin
                    r_fail       <= 1'b1;
                    r_first_fail <= w_index;
                end
`ifdef TRUTH_TABLE_SWEEPER_MISMATCH_COUNT_EN
                r_fail_cnt <= r_fail_cnt + {{N_IN{1'b0}}, 1'b1};
`endif
            end
            if (w_last) begin
                r_pass <= !(r_fail || w_mismatch);
            end
        end
    end

    assign f_in        = w_index;
    assign busy        = r_busy;
    assign done        = r_done;
    assign truth_table = r_tt;
    assign pass        = r_pass;
    assign first_fail  = r_first_fail;
    assign aborted     = r_aborted;
    assign o_dbg_state = r_state;
`ifdef TRUTH_TABLE_SWEEPER_MISMATCH_COUNT_EN
    assign fail_count  = r_fail_cnt;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper (N_IN=5). Main instance uses SETTLE=1; a second
// instance uses SETTLE=0. A cycle-count model predicts every output of the main
// instance each cycle; directed literal checks pin the model's key results.
// Define TRUTH_TABLE_SWEEPER_MISMATCH_COUNT_EN to also cover fail_count.
module tb_truth_table_sweeper;

    localparam int          S    = 1;
    localparam int          NV   = 32;
    localparam int          SLEN = NV * (S + 1);
    localparam logic [31:0] FUT  = 32'hCFC8_9F7F;

    logic        clk;
    logic        rst_n;
    logic        start, abort, start0;
    logic [31:0] expected, expected0;
    logic [31:0] fut_mask;
    logic [4:0]  f_in, f_in0;
    logic        f_out, f_out0;
    logic        busy, done, pass, aborted;
    logic        busy0, done0, pass0, aborted0;
    logic [31:0] truth_table, truth_table0;
    logic [4:0]  first_fail, first_fail0;
    logic [1:0]  dbg_state, dbg_state0;
`ifdef TRUTH_TABLE_SWEEPER_MISMATCH_COUNT_EN
    logic [5:0]  fail_count, fail_count0;
`endif

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 0;

    // Function under test: a table lookup on the driven vector.
    assign f_out  = fut_mask[f_in];
    assign f_out0 = fut_mask[f_in0];

    truth_table_sweeper #(.N_IN(5), .SETTLE(S)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .expected(expected), .f_in(f_in), .f_out(f_out), .busy(busy),
        .done(done), .truth_table(truth_table), .pass(pass),
        .first_fail(first_fail), .aborted(aborted),
`ifdef TRUTH_TABLE_SWEEPER_MISMATCH_COUNT_EN
        .fail_count(fail_count),
`endif
        .o_dbg_state(dbg_state)
    );

    truth_table_sweeper #(.N_IN(5), .SETTLE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(1'b0),
        .expected(expected0), .f_in(f_in0), .f_out(f_out0), .busy(busy0),
        .done(done0), .truth_table(truth_table0), .pass(pass0),
        .first_fail(first_fail0), .aborted(aborted0),
`ifdef TRUTH_TABLE_SWEEPER_MISMATCH_COUNT_EN
        .fail_count(fail_count0),
`endif
        .o_dbg_state(dbg_state0)
    );

    // Clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks edges since an accepted start; outputs follow from that count.
    bit          m_run     = 0;
    int          m_c       = 0;
    int          m_ncap    = 0;
    int          m_fin     = 0;
    bit          m_aborted = 0;
    bit          m_pass    = 0;
    logic [31:0] m_exp     = '0;
    logic [31:0] m_fmask   = '0;

    function automatic logic [31:0] cap_mask(input int n);
        if (n >= 32) return 32'hFFFF_FFFF;
        return (32'd1 << n) - 32'd1;
    endfunction

    function automatic int lowest_set(input logic [31:0] d);
        for (int i = 0; i < 32; i++) if (d[i]) return i;
        return 0;
    endfunction

    function automatic int popcount(input logic [31:0] d);
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(d[i]);
        return n;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_run = 0; m_c = 0; m_ncap = 0; m_fin = 0;
            m_aborted = 0; m_pass = 0; m_exp = '0; m_fmask = '0;
        end else if (abort) begin
            m_run = 0; m_aborted = 1; m_pass = 0;
        end else if (m_run) begin
            if (m_c == SLEN) begin
                m_run = 0;
            end else begin
                m_c++;
                m_ncap = m_c / (S + 1);
                m_fin  = (m_ncap > NV - 1) ? NV - 1 : m_ncap;
                if (m_c == SLEN) m_pass = ((m_fmask ^ m_exp) == 32'd0);
            end
        end else if (start) begin
            m_run = 1; m_c = 0; m_ncap = 0; m_fin = 0;
            m_aborted = 0; m_pass = 0; m_exp = expected; m_fmask = fut_mask;
        end
    end

    // Scoreboard compare: every cycle once reset has been applied.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [31:0] cm, diff;
            cm   = cap_mask(m_ncap);
            diff = (m_fmask ^ m_exp) & cm;
            check("mon_f_in",        32'(f_in),       32'(m_fin));
            check("mon_busy",        32'(busy),       32'(m_run && m_c < SLEN));
            check("mon_done",        32'(done),       32'(m_run && m_c == SLEN));
            check("mon_truth_table", truth_table,     m_fmask & cm);
            check("mon_pass",        32'(pass),       32'(m_pass));
            check("mon_first_fail",  32'(first_fail), 32'(lowest_set(diff)));
            check("mon_aborted",     32'(aborted),    32'(m_aborted));
`ifdef TRUTH_TABLE_SWEEPER_MISMATCH_COUNT_EN
            check("mon_fail_count",  32'(fail_count), 32'(popcount(diff)));
`endif
        end
    end

    // ---------------- driver tasks ----------------
    // Wait for done, counting cycles after the start edge (cycle 1 = after it).
    task automatic wait_done(input int cyc0, output int cyc);
        cyc = cyc0;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) check("done_timeout", 32'(cyc), 32'd0);
    endtask

    task automatic run_sweep(input logic [31:0] exp_mask, output int cyc);
        @(negedge clk);
        expected = exp_mask;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wait_done(1, cyc);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int cyc;
        int n;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; start0 = 1'b0;
        expected = '0; expected0 = '0; fut_mask = FUT;
        @(negedge clk);
        @(negedge clk);
        mon_en = 1;
        check("rst_busy",        32'(busy),        32'd0);
        check("rst_truth_table", truth_table,      32'd0);
        check("rst_f_in",        32'(f_in),        32'd0);
        rst_n = 1'b1;

        // 1: correct function
        run_sweep(FUT, cyc);
        check("t1_done_cycle",  32'(cyc),         32'd65);
        check("t1_truth_table", truth_table,      32'hCFC8_9F7F);
        check("t1_pass",        32'(pass),        32'd1);
        check("t1_first_fail",  32'(first_fail),  32'd0);
        check("t1_aborted",     32'(aborted),     32'd0);
        check("t1_busy_low",    32'(busy),        32'd0);
        check("t1_f_in_last",   32'(f_in),        32'd31);

        // 2: wrong mask bit 7
        run_sweep(32'hCFC8_9FFF, cyc);
        check("t2_pass",        32'(pass),        32'd0);
        check("t2_first_fail",  32'(first_fail),  32'd7);
`ifdef TRUTH_TABLE_SWEEPER_MISMATCH_COUNT_EN
        check("t2_fail_count",  32'(fail_count),  32'd1);
`endif

        // 3: constant functions
        fut_mask = 32'h0;
        run_sweep(32'h0000_0001, cyc);
        check("t3a_truth_table", truth_table,     32'd0);
        check("t3a_pass",        32'(pass),       32'd0);
        check("t3a_first_fail",  32'(first_fail), 32'd0);
`ifdef TRUTH_TABLE_SWEEPER_MISMATCH_COUNT_EN
        check("t3a_fail_count",  32'(fail_count), 32'd1);
`endif
        fut_mask = 32'hFFFF_FFFF;
        run_sweep(32'hFFFF_FFFF, cyc);
        check("t3b_pass",        32'(pass),       32'd1);
        fut_mask = FUT;

        // 4: abort 20 cycles after start
        @(negedge clk);
        expected = FUT;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        repeat (19) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t4_busy",        32'(busy),        32'd0);
        check("t4_aborted",     32'(aborted),     32'd1);
        check("t4_pass",        32'(pass),        32'd0);
        check("t4_partial_tt",  truth_table,      32'h0000_017F);
        repeat (70) @(negedge clk);
        run_sweep(FUT, cyc);
        check("t4_rerun_pass",  32'(pass),        32'd1);
        check("t4_rerun_abort", 32'(aborted),     32'd0);

        // 5a: start pulsed while busy is ignored
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(11, cyc);
        check("t5a_done_cycle", 32'(cyc),         32'd65);
        repeat (70) @(negedge clk);

        // 5b: start held high through DONE restarts right after IDLE returns
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        wait_done(1, cyc);
        check("t5b_done_cycle", 32'(cyc),         32'd65);
        n = 0;
        @(negedge clk);
        n++;
        while (!busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("t5b_restart_gap", 32'(n),          32'd2);
        start = 1'b0;
        wait_done(n + 1, cyc);
        check("t5b_second_pass", 32'(pass),       32'd1);

        // 6: reset mid-sweep
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t6_busy",        32'(busy),        32'd0);
        check("t6_f_in",        32'(f_in),        32'd0);
        check("t6_truth_table", truth_table,      32'd0);
        check("t6_first_fail",  32'(first_fail),  32'd0);
        run_sweep(FUT, cyc);
        check("t6_done_cycle",  32'(cyc),         32'd65);
        check("t6_pass",        32'(pass),        32'd1);

        // 7: SETTLE=0 instance
        @(negedge clk);
        expected0 = FUT;
        start0    = 1'b1;
        @(negedge clk);
        start0    = 1'b0;
        cyc = 1;
        while (!done0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("t7_done_cycle",  32'(cyc),         32'd33);
        check("t7_truth_table", truth_table0,     32'hCFC8_9F7F);
        check("t7_pass",        32'(pass0),       32'd1);
        @(negedge clk);
        check("t7_done_pulse",  32'(done0),       32'd0);

        repeat (3) @(negedge clk);
        mon_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

- Sequences an external N_IN-input combinational Boolean function (a simplified-logic module under test) through every input combination.
- Captures its output into a truth-table register and checks that register against an expected minterm mask.
- Reports pass/fail, the lowest mismatching index, and whether a sweep was aborted.
- Sits beside the simplification exercise modules as their on-chip equivalence checker.

## Interface
Parameters:
- N_IN, 5: input count of the function under test; truth table is 2**N_IN bits.
- SETTLE, 1: extra hold cycles per vector before sampling (0..15).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  begin sweep; honoured only in IDLE.
- abort  in  1  cancel sweep in progress.
- expected  in  2**N_IN  expected minterm mask; bit i = f(i); latched on accepted start.
- f_in  out  N_IN  vector driven to function under test; index bit N_IN-1 is the first input (MSB).
- f_out  in  1  function output.
- busy  out  1  high in SWEEP.
- done  out  1  one-cycle pulse on sweep completion.
- truth_table  out  2**N_IN  captured outputs.
- pass  out  1  truth_table == latched expected.
- first_fail  out  N_IN  lowest mismatching index; 0 if pass.
- aborted  out  1  last sweep was aborted.

## Operation
- States:
  - IDLE: waiting for start.
  - SWEEP: driving and sampling vectors.
  - DONE: completion cycle.
- Transitions:
  - IDLE -> SWEEP on start. On the same edge: latch expected, clear truth_table, pass, first_fail, aborted and the fail flag; set index and settle count to 0.
  - SWEEP: f_in = index.
    - Settle counter runs 0..SETTLE.
    - At count == SETTLE: write f_out into truth_table[index].
    - Mismatch check: compare f_out against latched expected[index]. On the first mismatch only, set the internal fail flag and first_fail = index.
    - Then increment index and reset the counter.
  - SWEEP -> DONE after sampling index 2**N_IN-1. No index wrap is ever driven.
  - DONE: done=1, pass = ~fail; -> IDLE next cycle.
  - Any state with abort=1 (priority over start) -> IDLE next edge. Sets aborted=1 and pass=0; done not pulsed; truth_table keeps partial contents.
- start while busy: ignored. expected changes after start: ignored.
- In IDLE, f_in holds its last value.
- Reset values (rst_n low at any edge, including mid-sweep):
  - state IDLE
  - f_in=0, busy=0, done=0, truth_table=0, pass=0, first_fail=0, aborted=0
  - internal counters 0

## Timing
- start sampled at edge 0; f_in=0 visible after edge 0; busy high after edge 0.
- Each vector occupies SETTLE+1 cycles. f_out is sampled at the last edge of that window.
- Sweep length 2**N_IN*(SETTLE+1) cycles. With N_IN=5, SETTLE=1: 64 cycles.
- done and pass valid in the cycle following the final sample: cycle 2**N_IN*(SETTLE+1)+1 after start, 65 with defaults.
- busy falls in that same cycle.
- start may be reasserted in the cycle after done and is accepted.
- All outputs are registered. No combinational path from f_out to any output.

## Configuration
- TRUTH_TABLE_SWEEPER_MISMATCH_COUNT_EN:
  - Defined: adds output fail_count [N_IN:0] counting all mismatching indices. Cleared on accepted start and on reset; valid with done.
  - Undefined: port and counter are absent; only first_fail is reported.

## Structure
- Shared package truth_table_sweeper_pkg:
  - State encoding (IDLE=2'd0, SWEEP=2'd1, DONE=2'd2).
  - Default N_IN/SETTLE constants.
  - Width function TT_W = 2**N_IN.
- Sub-module sweep_index_counter: settle counter plus index counter. Outputs index, sample strobe and last-vector flag; inputs clear and enable.
- The top owns the FSM, capture register and mismatch tracking.

## Test plan
- Function under test: a 5-input function whose minterm mask is 0xCFC8_9F7F (minterms 0-6, 8-12, 15, 19, 22-27, 30, 31).
1. Correct function: expected=0xCFC89F7F, SETTLE=1, start -> done at cycle 65; truth_table=0xCFC89F7F, pass=1, first_fail=0, aborted=0.
2. Wrong mask: expected=0xCFC89FFF (bit 7 set) -> pass=0, first_fail=7. With macro: fail_count=1.
3. Constant function f_out=0, expected=0x00000001 -> truth_table=0, pass=0, first_fail=0; with macro fail_count=1. Constant f_out=1, expected=0xFFFFFFFF -> pass=1.
4. Abort asserted 20 cycles after start -> IDLE next cycle; aborted=1, no done pulse, busy=0. A new start then completes normally with pass=1.
5. Control races:
   - start pulsed while busy -> ignored; the single done still arrives at cycle 65.
   - start held high through DONE -> a new sweep begins the cycle after done.
6. rst_n low at cycle 30 of a sweep -> all outputs 0 next edge; a following start completes normally.
   - SETTLE=0 variant: done at cycle 33.
